// File: rtl/bcrypt_tx_arbiter_pkg.sv
// ============================================================================
// bcrypt_tx_arbiter_pkg : shared state encodings and error bit indices
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcrypt_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    TXA_IDLE      = 2'd0,
    TXA_WAIT_INIT = 2'd1,
    TXA_WAIT_DATA = 2'd2,
    TXA_ERROR     = 2'd3
  } tx_arb_state_t;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_UNEXP   = 1;
  localparam int ERR_W       = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcrypt_tx_arbiter_rr_pick.sv
// ============================================================================
// rr_pick_onehot : first set request at or above a start pointer (wrapping)
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick_onehot #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int w_j;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!valid && req[w_j]) begin
        grant[w_j] = 1'b1;
        idx        = IW'(w_j);
        valid      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcrypt_tx_arbiter.sv
// ============================================================================
// bcrypt_tx_arbiter : schedules the shared bcrypt_data core bus across cores
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcrypt_tx_arbiter
  import bcrypt_tx_arbiter_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               data_ready,
  input  logic               init_ready,
  input  logic [15:0]        bcdata_pkt_id,
  input  logic               bcdata_gen_end,
  input  logic               init_tx_done,
  input  logic               data_tx_done,
  input  logic [N_CORES-1:0] core_idle,
  output logic               start_init_tx,
  output logic               start_data_tx,
  output logic [N_CORES-1:0] core_sel,
  output logic               pkt_done,
  output logic [15:0]        pkt_done_id,
  output logic [15:0]        pkt_cand_count,
  output logic [ERR_W-1:0]   error
);

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  tx_arb_state_t      r_state;
  logic [N_CORES-1:0] r_init_mask;
  logic [N_CORES-1:0] r_busy_mask;
  logic [N_CORES-1:0] r_core_sel;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_cur_idx;
  logic [TW-1:0]      r_tmo_cnt;
  logic [15:0]        r_cand_cnt;
  logic [15:0]        r_pkt_id;
  logic               r_is_dummy;
  logic               r_start_init;
  logic               r_start_data;
  logic               r_pkt_done;
  logic [15:0]        r_pkt_done_id;
  logic [15:0]        r_pkt_cand_count;
  logic [ERR_W-1:0]   r_error;

  logic [N_CORES-1:0] w_eligible;
  logic [N_CORES-1:0] w_init_req;
  logic [N_CORES-1:0] w_data_req;
  logic [N_CORES-1:0] w_init_grant;
  logic [N_CORES-1:0] w_data_grant;
  logic [IW-1:0]      w_init_idx;
  logic [IW-1:0]      w_data_idx;
  logic               w_init_vld;
  logic               w_data_vld;
  logic [IW-1:0]      w_rr_next;

  // A core just handed data stays blocked until it is seen leaving idle.
  assign w_eligible = core_idle & ~r_busy_mask;
  assign w_init_req = w_eligible & ~r_init_mask;
  assign w_data_req = w_eligible & r_init_mask;
  assign w_rr_next  = (w_data_idx == IW'(N_CORES - 1)) ? '0 : w_data_idx + IW'(1);

  rr_pick_onehot #(.N(N_CORES), .IW(IW)) u_pick_init (
    .req   (w_init_req),
    .ptr   ('0),
    .grant (w_init_grant),
    .idx   (w_init_idx),
    .valid (w_init_vld)
  );

  rr_pick_onehot #(.N(N_CORES), .IW(IW)) u_pick_data (
    .req   (w_data_req),
    .ptr   (r_rr_ptr),
    .grant (w_data_grant),
    .idx   (w_data_idx),
    .valid (w_data_vld)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state          <= TXA_IDLE;
      r_init_mask      <= '0;
      r_busy_mask      <= '0;
      r_core_sel       <= '0;
      r_rr_ptr         <= '0;
      r_cur_idx        <= '0;
      r_tmo_cnt        <= '0;
      r_cand_cnt       <= '0;
      r_pkt_id         <= '0;
      r_is_dummy       <= 1'b0;
      r_start_init     <= 1'b0;
      r_start_data     <= 1'b0;
      r_pkt_done       <= 1'b0;
      r_pkt_done_id    <= '0;
      r_pkt_cand_count <= '0;
      r_error          <= '0;
    end else begin
      r_start_init <= 1'b0;
      r_start_data <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_busy_mask  <= r_busy_mask & core_idle;
      case (r_state)
        TXA_IDLE: begin
          if (init_tx_done || data_tx_done) begin
            r_error[ERR_UNEXP] <= 1'b1;
            r_core_sel         <= '0;
            r_state            <= TXA_ERROR;
          end else if (init_ready && w_init_vld) begin
            r_start_init <= 1'b1;
            r_core_sel   <= w_init_grant;
            r_cur_idx    <= w_init_idx;
            r_tmo_cnt    <= '0;
            r_state      <= TXA_WAIT_INIT;
          end else if (data_ready && bcdata_gen_end) begin
            r_start_data <= 1'b1;
            r_core_sel   <= '0;
            r_is_dummy   <= 1'b1;
            r_pkt_id     <= bcdata_pkt_id;
            r_tmo_cnt    <= '0;
            r_state      <= TXA_WAIT_DATA;
          end else if (data_ready && w_data_vld) begin
            r_start_data <= 1'b1;
            r_core_sel   <= w_data_grant;
            r_cur_idx    <= w_data_idx;
            r_is_dummy   <= 1'b0;
            r_rr_ptr     <= w_rr_next;
            r_tmo_cnt    <= '0;
            r_state      <= TXA_WAIT_DATA;
          end
        end
        TXA_WAIT_INIT: begin
          if (data_tx_done) begin
            r_error[ERR_UNEXP] <= 1'b1;
            r_core_sel         <= '0;
            r_state            <= TXA_ERROR;
          end else if (init_tx_done) begin
            r_init_mask[r_cur_idx] <= 1'b1;
            r_core_sel             <= '0;
            r_state                <= TXA_IDLE;
          end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
            r_error[ERR_TIMEOUT] <= 1'b1;
            r_core_sel           <= '0;
            r_state              <= TXA_ERROR;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        TXA_WAIT_DATA: begin
          if (init_tx_done) begin
            r_error[ERR_UNEXP] <= 1'b1;
            r_core_sel         <= '0;
            r_state            <= TXA_ERROR;
          end else if (data_tx_done) begin
            if (r_is_dummy) begin
              r_pkt_done       <= 1'b1;
              r_pkt_done_id    <= r_pkt_id;
              r_pkt_cand_count <= r_cand_cnt;
              r_cand_cnt       <= '0;
            end else begin
              r_busy_mask[r_cur_idx] <= 1'b1;
              r_cand_cnt             <= sat_inc16(r_cand_cnt);
            end
            r_core_sel <= '0;
            r_state    <= TXA_IDLE;
          end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
            r_error[ERR_TIMEOUT] <= 1'b1;
            r_core_sel           <= '0;
            r_state              <= TXA_ERROR;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        TXA_ERROR: begin
          r_core_sel <= '0;
        end
        default: begin
          r_state <= TXA_ERROR;
        end
      endcase
    end
  end

  assign start_init_tx  = r_start_init;
  assign start_data_tx  = r_start_data;
  assign core_sel       = r_core_sel;
  assign pkt_done       = r_pkt_done;
  assign pkt_done_id    = r_pkt_done_id;
  assign pkt_cand_count = r_pkt_cand_count;
  assign error          = r_error;

endmodule

`default_nettype wire

// File: tb/tb_bcrypt_tx_arbiter.sv
// ============================================================================
// tb_bcrypt_tx_arbiter : scoreboard bench with a bcrypt_data/core responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bcrypt_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 64;
  localparam int K_INIT = 0;
  localparam int K_DATA = 1;
  localparam int K_PKT  = 2;

  typedef struct {
    int          kind;
    logic [N-1:0] sel;
    logic [15:0] id;
    logic [15:0] cnt;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         data_ready = 1'b0;
  logic         init_ready = 1'b0;
  logic [15:0]  bcdata_pkt_id = '0;
  logic         bcdata_gen_end = 1'b0;
  logic         init_tx_done = 1'b0;
  logic         data_tx_done = 1'b0;
  logic [N-1:0] core_idle = '1;
  logic         start_init_tx;
  logic         start_data_tx;
  logic [N-1:0] core_sel;
  logic         pkt_done;
  logic [15:0]  pkt_done_id;
  logic [15:0]  pkt_cand_count;
  logic [1:0]   error;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_data_done = 0;
  int           inj_req = 0;
  int           inj_ack = 0;
  logic [N-1:0] stuck = '0;
  logic         withhold = 1'b0;

  bcrypt_tx_arbiter #(.N_CORES(N), .TIMEOUT(TMO)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .data_ready     (data_ready),
    .init_ready     (init_ready),
    .bcdata_pkt_id  (bcdata_pkt_id),
    .bcdata_gen_end (bcdata_gen_end),
    .init_tx_done   (init_tx_done),
    .data_tx_done   (data_tx_done),
    .core_idle      (core_idle),
    .start_init_tx  (start_init_tx),
    .start_data_tx  (start_data_tx),
    .core_sel       (core_sel),
    .pkt_done       (pkt_done),
    .pkt_done_id    (pkt_done_id),
    .pkt_cand_count (pkt_cand_count),
    .error          (error)
  );

  always #5 CLK = ~CLK;

  function automatic string kname(input int k);
    return (k == K_INIT) ? "start_init" : (k == K_DATA) ? "start_data" : "pkt_done";
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [N-1:0] sel, input logic [15:0] id,
                      input logic [15:0] cnt);
    exp_t e;
    e.kind = kind; e.sel = sel; e.id = id; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int kind);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s sel %b, required no event", kname(kind), core_sel);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind != K_PKT && core_sel !== e.sel) ||
          (kind == K_PKT && (pkt_done_id !== e.id || pkt_cand_count !== e.cnt))) begin
        n_fail++;
        $display("FAIL sb_%s: got %s sel %b id %h cnt %0d, required %s sel %b id %h cnt %0d",
                 kname(e.kind), kname(kind), core_sel, pkt_done_id, pkt_cand_count,
                 kname(e.kind), e.sel, e.id, e.cnt);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a start or pkt_done.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        if (start_init_tx) mon_event(K_INIT);
        if (start_data_tx) mon_event(K_DATA);
        if (pkt_done)      mon_event(K_PKT);
      end
    end
  end

  // Responder: bcrypt_data done pulses plus a simple per-core idle model.
  initial begin
    int init_cd;
    int data_cd;
    int drop_cd[N];
    int run_cd[N];
    init_cd = 0;
    data_cd = 0;
    for (int i = 0; i < N; i++) begin drop_cd[i] = 0; run_cd[i] = 0; end
    forever begin
      @(negedge CLK);
      init_tx_done = 1'b0;
      data_tx_done = 1'b0;
      if (!RST_N) begin
        init_cd = 0;
        data_cd = 0;
        core_idle = '1;
        for (int i = 0; i < N; i++) begin drop_cd[i] = 0; run_cd[i] = 0; end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (drop_cd[i] > 0) begin
            drop_cd[i]--;
            if (drop_cd[i] == 0) begin core_idle[i] = 1'b0; run_cd[i] = 6; end
          end else if (run_cd[i] > 0) begin
            run_cd[i]--;
            if (run_cd[i] == 0) core_idle[i] = 1'b1;
          end
        end
        if (init_cd > 0) begin
          init_cd--;
          if (init_cd == 0) init_tx_done = 1'b1;
        end
        if (data_cd > 0) begin
          data_cd--;
          if (data_cd == 0) begin
            data_tx_done = 1'b1;
            n_data_done++;
            for (int i = 0; i < N; i++)
              if (core_sel[i] && !stuck[i]) drop_cd[i] = 3;
          end
        end
        if (start_init_tx) init_cd = 2;
        if (start_data_tx && !withhold) data_cd = 2;
        if (inj_req != inj_ack) begin
          init_tx_done = 1'b1;
          inj_ack++;
        end
      end
    end
  end

  task automatic wait_start(input int kind);
    for (int t = 0; t < 100; t++) begin
      @(negedge CLK);
      if (kind == K_INIT ? start_init_tx : start_data_tx) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_%s: got no pulse in 100 cycles, required a pulse", kname(kind));
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    data_ready = 1'b0; init_ready = 1'b0;
    bcdata_gen_end = 1'b0; bcdata_pkt_id = '0;
    stuck = '0; withhold = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_outputs", {23'd0, start_init_tx, start_data_tx, core_sel, pkt_done,
                            pkt_done_id, pkt_cand_count, error}, 64'd0);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic do_init_all();
    for (int i = 0; i < N; i++) push(K_INIT, N'(1) << i, '0, '0);
    init_ready = 1'b1;
    for (int i = 0; i < N; i++) wait_start(K_INIT);
    repeat (10) @(negedge CLK);
    init_ready = 1'b0;
  endtask

  task automatic do_batch(input logic gen_end, input logic [15:0] pid,
                          input logic [N-1:0] sel, input logic [15:0] cnt);
    int dd;
    push(K_DATA, sel, '0, '0);
    if (gen_end) push(K_PKT, '0, pid, cnt);
    dd = n_data_done;
    data_ready = 1'b1; bcdata_gen_end = gen_end; bcdata_pkt_id = pid;
    wait_start(K_DATA);
    data_ready = 1'b0; bcdata_gen_end = 1'b0;
    for (int t = 0; t < 50 && n_data_done == dd; t++) @(negedge CLK);
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_drained(input string name);
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [N-1:0] ord2[6];
    logic [N-1:0] ord4[8];
    ord2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    ord4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};

    // Initialisation sweep then round-robin data.
    do_reset();
    do_init_all();
    check_drained("t1_init_drained");
    for (int i = 0; i < 6; i++) do_batch(1'b0, 16'h0001, ord2[i], '0);
    check_drained("t2_rr_drained");

    // Packet accounting across a dummy boundary.
    do_reset();
    do_init_all();
    for (int i = 0; i < 5; i++) do_batch(1'b0, 16'h00A5, ord2[i], '0);
    do_batch(1'b1, 16'h00A5, 4'b0000, 16'd5);
    do_batch(1'b0, 16'h00A6, 4'b0010, '0);
    do_batch(1'b1, 16'h00A6, 4'b0000, 16'd1);
    check_drained("t3_pkt_drained");

    // Core 2 never leaves idle after its batch.
    do_reset();
    do_init_all();
    stuck = 4'b0100;
    for (int i = 0; i < 8; i++) do_batch(1'b0, 16'h0002, ord4[i], '0);
    check_drained("t4_stuck_drained");

    // Timeout on a withheld data_tx_done.
    do_reset();
    do_init_all();
    withhold = 1'b1;
    push(K_DATA, 4'b0001, '0, '0);
    data_ready = 1'b1;
    wait_start(K_DATA);
    repeat (TMO - 1) @(negedge CLK);
    check("t5_err_before", {62'd0, error}, 64'd0);
    check("t5_sel_before", 64'(core_sel), 64'h1);
    @(negedge CLK);
    check("t5_err_timeout", {62'd0, error}, 64'h1);
    check("t5_sel_cleared", 64'(core_sel), 64'h0);
    repeat (20) @(negedge CLK);
    check("t5_err_sticky", {62'd0, error}, 64'h1);
    data_ready = 1'b0;
    check_drained("t5_drained");

    // Unexpected done in IDLE, then reset mid-transfer.
    do_reset();
    @(negedge CLK);
    inj_req++;
    repeat (3) @(negedge CLK);
    check("t6_err_unexp", {62'd0, error}, 64'h2);
    do_reset();
    do_init_all();
    withhold = 1'b1;
    push(K_DATA, 4'b0001, '0, '0);
    data_ready = 1'b1;
    wait_start(K_DATA);
    data_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check("t6_sel_in_wait", 64'(core_sel), 64'h1);
    #2 RST_N = 1'b0;
    #1 check("t6_async_reset", {23'd0, start_init_tx, start_data_tx, core_sel, pkt_done,
                                pkt_done_id, pkt_cand_count, error}, 64'd0);
    check_drained("t6_drained");
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
